// File: rtl/riscv_m_pkg.sv
// Shared RV32M encodings, FSM states and constants for the iterative multiply/divide unit.
package riscv_m_pkg;

  typedef enum logic [2:0] {
    F3Mul    = 3'b000,
    F3Mulh   = 3'b001,
    F3Mulhsu = 3'b010,
    F3Mulhu  = 3'b011,
    F3Div    = 3'b100,
    F3Divu   = 3'b101,
    F3Rem    = 3'b110,
    F3Remu   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFin  = 2'd2
  } estado_e;

  localparam logic [5:0]  ITER_MAX = 6'd31;
  localparam logic [31:0] DIV0_RES = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;

  // Two's-complement negation when n is set.
  function automatic logic [31:0] neg_if(input logic n, input logic [31:0] v);
    return n ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/divisor_restaurador.sv
// One restoring-division step: shifts in the next dividend bit and produces one quotient bit.
// Only built when MUL_DIV_DIVISION_EN is defined.
`ifdef MUL_DIV_DIVISION_EN
module divisor_restaurador #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] resto_i,
  input  logic [XLEN-1:0] cociente_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] resto_o,
  output logic [XLEN-1:0] cociente_o
);

  logic [XLEN:0] parcial;
  logic [XLEN:0] dif;

  always_comb begin
    parcial = {resto_i, cociente_i[XLEN-1]};
    dif     = parcial - {1'b0, divisor_i};
    // A borrow out of the top bit means the divisor did not fit: restore.
    if (dif[XLEN]) begin
      resto_o    = parcial[XLEN-1:0];
      cociente_o = {cociente_i[XLEN-2:0], 1'b0};
    end else begin
      resto_o    = dif[XLEN-1:0];
      cociente_o = {cociente_i[XLEN-2:0], 1'b1};
    end
  end

endmodule
`endif

// File: rtl/mul_div_iterativa.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring-division steps per operation.
// Define MUL_DIV_DIVISION_EN to build the divider; otherwise div/rem ops return 0 in one cycle.
module mul_div_iterativa
  import riscv_m_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inicio,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] entrada_A,
  input  logic [XLEN-1:0] entrada_B,
  output logic            ocupado,
  output logic            listo,
  output logic [XLEN-1:0] resultado
);

  estado_e     estado_q, estado_d;
  logic [5:0]  cnt_q, cnt_d;
  funct3_e     op_q, op_d;
  logic [31:0] opnd_q, opnd_d;
  logic        neg_q, neg_d;
  logic [63:0] prod_q, prod_d;
  logic        ocupado_q, ocupado_d;
  logic        listo_q, listo_d;
  logic [31:0] resultado_q, resultado_d;

  funct3_e     op_in;
  logic        a_sgn, b_sgn;
  logic [31:0] mag_a, mag_b;
  logic        especial;
  logic [31:0] res_especial;
  logic [32:0] suma;
  logic [63:0] mul_paso, paso, prod_fix;
  logic [31:0] res_fin;

  always_comb begin
    op_in = funct3_e'(funct3);
    a_sgn = entrada_A[31] & (op_in inside {F3Mul, F3Mulh, F3Mulhsu, F3Div, F3Rem});
    b_sgn = entrada_B[31] & (op_in inside {F3Mul, F3Mulh, F3Div, F3Rem});
    mag_a = neg_if(a_sgn, entrada_A);
    mag_b = neg_if(b_sgn, entrada_B);
  end

  always_comb begin
    especial     = 1'b0;
    res_especial = '0;
`ifdef MUL_DIV_DIVISION_EN
    if (funct3[2] && entrada_B == '0) begin
      especial     = 1'b1;
      res_especial = funct3[1] ? entrada_A : DIV0_RES;
    end else if (funct3[2] && !funct3[0] && entrada_A == INT_MIN && entrada_B == DIV0_RES) begin
      especial     = 1'b1;
      res_especial = funct3[1] ? 32'd0 : INT_MIN;
    end
`else
    especial = funct3[2];
`endif
  end

  // Shift-add: conditionally add the multiplicand into the high half, then shift right.
  always_comb begin
    suma     = {1'b0, prod_q[63:32]} + {1'b0, (prod_q[0] ? opnd_q : 32'd0)};
    mul_paso = {suma, prod_q[31:1]};
  end

`ifdef MUL_DIV_DIVISION_EN
  logic [31:0] div_resto, div_coc;

  divisor_restaurador #(
    .XLEN(32)
  ) u_divisor (
    .resto_i   (prod_q[63:32]),
    .cociente_i(prod_q[31:0]),
    .divisor_i (opnd_q),
    .resto_o   (div_resto),
    .cociente_o(div_coc)
  );

  assign paso = op_q[2] ? {div_resto, div_coc} : mul_paso;
`else
  assign paso = mul_paso;
`endif

  always_comb begin
    prod_fix = neg_q ? (~paso + 64'd1) : paso;
    unique case (op_q)
      F3Mul:                     res_fin = prod_fix[31:0];
      F3Mulh, F3Mulhsu, F3Mulhu: res_fin = prod_fix[63:32];
`ifdef MUL_DIV_DIVISION_EN
      F3Div, F3Divu:             res_fin = neg_if(neg_q, paso[31:0]);
      F3Rem, F3Remu:             res_fin = neg_if(neg_q, paso[63:32]);
`endif
      default:                   res_fin = '0;
    endcase
  end

  always_comb begin
    estado_d    = estado_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    opnd_d      = opnd_q;
    neg_d       = neg_q;
    prod_d      = prod_q;
    ocupado_d   = ocupado_q;
    listo_d     = 1'b0;
    resultado_d = resultado_q;
    unique case (estado_q)
      StIdle: begin
        if (inicio) begin
          op_d      = op_in;
          cnt_d     = '0;
          ocupado_d = 1'b1;
          if (especial) begin
            estado_d    = StFin;
            listo_d     = 1'b1;
            resultado_d = res_especial;
          end else begin
            estado_d = StCalc;
            neg_d    = (op_in == F3Rem) ? a_sgn : (a_sgn ^ b_sgn);
            // Multiply walks B's bits adding |A|; divide shifts |A| out against |B|.
            opnd_d   = funct3[2] ? mag_b : mag_a;
            prod_d   = {32'd0, (funct3[2] ? mag_a : mag_b)};
          end
        end
      end
      StCalc: begin
        prod_d = paso;
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == ITER_MAX) begin
          estado_d    = StFin;
          listo_d     = 1'b1;
          resultado_d = res_fin;
        end
      end
      StFin: begin
        estado_d  = StIdle;
        ocupado_d = 1'b0;
        cnt_d     = '0;
      end
      default: begin
        estado_d  = StIdle;
        ocupado_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q    <= StIdle;
      cnt_q       <= '0;
      op_q        <= F3Mul;
      opnd_q      <= '0;
      neg_q       <= 1'b0;
      prod_q      <= '0;
      ocupado_q   <= 1'b0;
      listo_q     <= 1'b0;
      resultado_q <= '0;
    end else begin
      estado_q    <= estado_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      opnd_q      <= opnd_d;
      neg_q       <= neg_d;
      prod_q      <= prod_d;
      ocupado_q   <= ocupado_d;
      listo_q     <= listo_d;
      resultado_q <= resultado_d;
    end
  end

  assign ocupado   = ocupado_q;
  assign listo     = listo_q;
  assign resultado = resultado_q;

endmodule

// File: tb/tb_mul_div_iterativa.sv
// Self-checking bench for mul_div_iterativa: arithmetic reference model plus directed vectors.
module tb_mul_div_iterativa;

  logic        clk = 1'b0;
  logic        rst;
  logic        inicio;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        ocupado, listo;
  logic [31:0] resultado;

  int n_tests = 0;
  int n_fail  = 0;

  mul_div_iterativa #(
    .XLEN(32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .inicio   (inicio),
    .funct3   (funct3),
    .entrada_A(op_a),
    .entrada_B(op_b),
    .ocupado  (ocupado),
    .listo    (listo),
    .resultado(resultado)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference result straight from the RV32M definitions.
  function automatic logic [31:0] m_result(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int ia, ib;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ia  = $signed(a);
    ib  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      default: begin
`ifdef MUL_DIV_DIVISION_EN
        if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
        if (f == 3'b100) begin
          if (ovf) return 32'h8000_0000;
          return ia / ib;
        end
        if (f == 3'b110) begin
          if (ovf) return 32'd0;
          return ia % ib;
        end
        if (f == 3'b101) return a / b;
        return a % b;
`else
        return 32'd0;
`endif
      end
    endcase
  endfunction

  function automatic int m_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_DIV_DIVISION_EN
    if (f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
`else
    return f[2] ? 1 : 33;
`endif
  endfunction

  // Expected values of division vectors depend on whether the divider is built.
  function automatic logic [31:0] dv(input logic [31:0] v);
`ifdef MUL_DIV_DIVISION_EN
    return v;
`else
    return (v & 32'd0);
`endif
  endfunction

  function automatic int dl(input int l);
`ifdef MUL_DIV_DIVISION_EN
    return l;
`else
    return (l > 0) ? 1 : 1;
`endif
  endfunction

  // Model: an accepted start at edge s is busy in cycles s+1..s+lat, listo in cycle s+lat.
  int          cyc     = 0;
  int          m_start = -1;
  int          m_done  = -1;
  logic [31:0] m_res   = '0;
  logic [31:0] m_pend  = '0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_start <= -1;
      m_done  <= -1;
      m_res   <= '0;
      m_valid <= 1'b1;
    end else if (inicio && !(m_start < cyc && cyc <= m_done)) begin
      m_start <= cyc;
      m_done  <= cyc + m_lat(funct3, op_a, op_b);
      m_pend  <= m_result(funct3, op_a, op_b);
      if (m_lat(funct3, op_a, op_b) == 1) m_res <= m_result(funct3, op_a, op_b);
    end else if (cyc + 1 == m_done) begin
      m_res <= m_pend;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("ocupado", 32'(ocupado), 32'((m_start < cyc) && (cyc <= m_done)));
      check("listo", 32'(listo), 32'(cyc == m_done));
      check("resultado", resultado, m_res);
    end
  end

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] exp, input int lat,
                        input int glitch);
    int k;
    bit seen;
    @(negedge clk);
    inicio = 1'b1;
    funct3 = f;
    op_a   = va;
    op_b   = vb;
    k      = 0;
    seen   = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (listo === 1'b1) begin
        seen = 1'b1;
      end else begin
        // Upstream keeps changing after acceptance; a late inicio must be ignored.
        inicio = (glitch != 0) && (k == glitch);
        funct3 = 3'($urandom);
        op_a   = $urandom;
        op_b   = $urandom;
      end
    end
    inicio = 1'b0;
    check({name, " listo_seen"}, 32'(seen), 32'd1);
    check({name, " latency"}, k, lat);
    check({name, " value"}, resultado, exp);
  endtask

  task automatic run_reset_mid();
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    inicio = 1'b1;
    funct3 = 3'b000;
    op_a   = 32'd123;
    op_b   = 32'd456;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      inicio = 1'b0;
      if (listo === 1'b1) seen = 1'b1;
    end
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid ocupado", 32'(ocupado), 32'd0);
    check("rst_mid resultado", resultado, 32'd0);
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (listo === 1'b1) seen = 1'b1;
    end
    check("rst_mid no_listo", 32'(seen), 32'd0);
  endtask

  initial begin
    rst    = 1'b1;
    inicio = 1'b0;
    funct3 = 3'b000;
    op_a   = '0;
    op_b   = '0;
    repeat (2) @(negedge clk);
    check("reset ocupado", 32'(ocupado), 32'd0);
    check("reset listo", 32'(listo), 32'd0);
    check("reset resultado", resultado, 32'd0);
    rst = 1'b0;

    run_op("mul_neg", 3'b000, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 33, 10);
    run_op("mulhu", 3'b011, 32'd7, 32'hFFFF_FFFA, 32'h0000_0006, 33, 0);
    run_op("mulh", 3'b001, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 33, 0);
    run_op("mulhsu_neg", 3'b010, 32'hFFFF_FFFA, 32'd7, 32'hFFFF_FFFF, 33, 0);
    run_op("mulhsu_min", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 0);
    run_op("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0);
    run_op("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
    run_op("mul_wrap", 3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 33, 0);
    run_op("mulhu_wrap", 3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 33, 0);
    run_op("div_neg", 3'b100, 32'hFFFF_FFEC, 32'd3, dv(32'hFFFF_FFFA), dl(33), 0);
    run_op("rem_neg", 3'b110, 32'hFFFF_FFEC, 32'd3, dv(32'hFFFF_FFFE), dl(33), 0);
    run_op("divu_zero", 3'b101, 32'd5, 32'd0, dv(32'hFFFF_FFFF), 1, 0);
    run_op("remu_zero", 3'b111, 32'd5, 32'd0, dv(32'd5), 1, 0);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, dv(32'h8000_0000), 1, 0);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, dv(32'd0), 1, 0);
    run_op("divu_big", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, dv(32'd0), dl(33), 0);
    run_op("remu_big", 3'b111, 32'h8000_0000, 32'hFFFF_FFFF, dv(32'h8000_0000), dl(33), 0);
    run_op("div_negb", 3'b100, 32'd20, 32'hFFFF_FFFD, dv(32'hFFFF_FFFA), dl(33), 0);
    run_op("rem_negb", 3'b110, 32'd20, 32'hFFFF_FFFD, dv(32'd2), dl(33), 0);
    run_op("divu", 3'b101, 32'd100, 32'd7, dv(32'd14), dl(33), 0);
    run_op("remu", 3'b111, 32'd100, 32'd7, dv(32'd2), dl(33), 0);
    run_op("div_zero", 3'b100, 32'd0, 32'd0, dv(32'hFFFF_FFFF), 1, 0);
    run_op("rem_zero", 3'b110, 32'hFFFF_FFF9, 32'd0, dv(32'hFFFF_FFF9), 1, 0);
    run_op("mul_pre_rst", 3'b000, 32'd9, 32'd11, 32'd99, 33, 0);
    run_reset_mid();
    run_op("mul_post_rst", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 33, 0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
